// File: rtl/vga_pkg.sv
// Shared timing defaults, coordinate widths and run-state encoding for the
// framebuffer scan-out block.
package vga_pkg;

    localparam int unsigned X_W = 10;
    localparam int unsigned Y_W = 9;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } run_state_t;

endpackage

// File: rtl/fb_scanout_if.sv
// Pixel-tick, framebuffer read and VGA output bundle of fb_scanout.
// master = scan-out engine, slave = framebuffer/display environment.
interface fb_scanout_if;
    import vga_pkg::*;

    logic           pix_ce;
    logic           start_process;
    logic [X_W-1:0] rd_x;
    logic [Y_W-1:0] rd_y;
    logic           rd_en;
    logic           rd_data;
    logic           vga_pixel;
    logic           vga_hs;
    logic           vga_vs;
    logic           vga_blank_n;
    logic           end_process;

    modport master (
        input  pix_ce, start_process, rd_data,
        output rd_x, rd_y, rd_en, vga_pixel, vga_hs, vga_vs, vga_blank_n, end_process
    );

    modport slave (
        output pix_ce, start_process, rd_data,
        input  rd_x, rd_y, rd_en, vga_pixel, vga_hs, vga_vs, vga_blank_n, end_process
    );

endinterface

// File: rtl/vga_timing.sv
// Horizontal/vertical position counters with wrap and active/sync region decode.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    localparam int unsigned LINE_TICKS  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW = $clog2(LINE_TICKS),
    localparam int unsigned VW = $clog2(FRAME_LINES)
) (
    input  logic          clk,
    input  logic          program_resetn,
    input  logic          advance,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          visible,
    output logic          h_sync,
    output logic          v_sync,
    output logic          frame_end
);

    localparam logic [HW-1:0] H_LAST   = HW'(LINE_TICKS - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(FRAME_LINES - 1);
    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    always_ff @(posedge clk) begin
        if (!program_resetn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (advance) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    assign visible   = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    assign h_sync    = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    assign v_sync    = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: run FSM, read addressing and one-tick VGA output stage.
// Optional FB_SCANOUT_BORDER_EN forces a lit one-pixel border around the visible area.
module fb_scanout
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF
) (
    input  logic         clk,
    input  logic         program_resetn,
    fb_scanout_if.master bus
);

    localparam int unsigned HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int unsigned VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    run_state_t    state;
    logic          running;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          visible;
    logic          h_sync;
    logic          v_sync;
    logic          frame_end;
    logic          pix_next;

    assign running = (state == SCAN);

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk            (clk),
        .program_resetn (program_resetn),
        .advance        (bus.pix_ce & running),
        .h_cnt          (h_cnt),
        .v_cnt          (v_cnt),
        .visible        (visible),
        .h_sync         (h_sync),
        .v_sync         (v_sync),
        .frame_end      (frame_end)
    );

    assign bus.rd_en = running & visible;
    assign bus.rd_x  = bus.rd_en ? X_W'(h_cnt) : '0;
    assign bus.rd_y  = bus.rd_en ? Y_W'(v_cnt) : '0;

`ifdef FB_SCANOUT_BORDER_EN
    localparam logic [HW-1:0] H_EDGE = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] V_EDGE = VW'(V_ACTIVE - 1);
    logic border;
    assign border   = (h_cnt == '0) || (h_cnt == H_EDGE) || (v_cnt == '0) || (v_cnt == V_EDGE);
    assign pix_next = (bus.rd_data | border) & bus.rd_en;
`else
    assign pix_next = bus.rd_data & bus.rd_en;
`endif

    // Outputs are captured from the same tick's counters, so they trail the
    // read address by exactly one pixel tick and stay mutually aligned.
    always_ff @(posedge clk) begin
        if (!program_resetn) begin
            state           <= IDLE;
            bus.vga_pixel   <= 1'b0;
            bus.vga_blank_n <= 1'b0;
            bus.vga_hs      <= 1'b1;
            bus.vga_vs      <= 1'b1;
            bus.end_process <= 1'b0;
        end else begin
            bus.end_process <= 1'b0;
            if (bus.pix_ce) begin
                bus.vga_pixel   <= pix_next;
                bus.vga_blank_n <= bus.rd_en;
                bus.vga_hs      <= ~(running & h_sync);
                bus.vga_vs      <= ~(running & v_sync);
                case (state)
                    IDLE: begin
                        if (bus.start_process) begin
                            state <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (frame_end) begin
                            bus.end_process <= 1'b1;
                            if (!bus.start_process) begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout at reduced timing; honours FB_SCANOUT_BORDER_EN.
module tb_fb_scanout;

    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HS  = 4;
    localparam int HBP = 3;
    localparam int VA  = 8;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 2;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FT  = HT * VT;

    typedef struct {
        bit         rd_en;
        int         rd_x;
        int         rd_y;
        logic [3:0] out;
        bit         endp;
    } exp_t;

    logic clk;
    logic program_resetn;

    fb_scanout_if bus ();

    fb_scanout #(
        .H_ACTIVE (HA),
        .H_FP     (HFP),
        .H_SYNC   (HS),
        .H_BP     (HBP),
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VS),
        .V_BP     (VBP)
    ) dut (
        .clk            (clk),
        .program_resetn (program_resetn),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    bit   running = 1'b0;
    int   pos = 0;

    int   tick_count = 0;
    int   en_count = 0;
    int   hs_low = 0;
    int   vs_low = 0;
    int   end_count = 0;
    int   last_end_tick = 0;
    int   end_gap = 0;

    function automatic void check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: one linear position within the frame, split into (h, v) by division.
    task automatic model_step(input bit start, input bit data, output exp_t e);
        int h, v;
        bit vis, in_hs, in_vs, border;
        h = pos % HT;
        v = pos / HT;
        vis = running && h < HA && v < VA;
        border = 1'b0;
`ifdef FB_SCANOUT_BORDER_EN
        border = (h == 0) || (h == HA - 1) || (v == 0) || (v == VA - 1);
`endif
        in_hs = running && h >= HA + HFP && h < HA + HFP + HS;
        in_vs = running && v >= VA + VFP && v < VA + VFP + VS;
        e.rd_en = vis;
        e.rd_x  = vis ? h : 0;
        e.rd_y  = vis ? v : 0;
        e.out   = {vis && (data || border), vis, !in_hs, !in_vs};
        e.endp  = running && pos == FT - 1;
        if (running) begin
            pos = (pos + 1) % FT;
            if (pos == 0 && !start) running = 1'b0;
        end else if (start) begin
            running = 1'b1;
        end
    endtask

    task automatic tick(input bit start, input bit data);
        exp_t e;
        @(negedge clk);
        model_step(start, data, e);
        sb.push_back(e);
        bus.pix_ce = 1'b1;
        bus.start_process = start;
        bus.rd_data = data;
        @(negedge clk);
        bus.pix_ce = 1'b0;
        if ($urandom_range(0, 1) == 1) @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        program_resetn = 1'b0;
        bus.pix_ce = 1'b1;
        bus.start_process = 1'b1;
        @(negedge clk);
        bus.pix_ce = 1'b0;
        repeat (cycles) @(negedge clk);
        program_resetn = 1'b1;
        running = 1'b0;
        pos = 0;
    endtask

    initial begin : monitor
        exp_t       e;
        bit         have;
        logic [3:0] act;
        logic [3:0] last_out;
        last_out = 4'b0011;
        forever begin
            @(negedge clk);
            #1;
            have = 1'b0;
            if (bus.pix_ce && program_resetn) begin
                tick_count++;
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL scoreboard_empty: tick with no expected entry at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    have = 1'b1;
                    check("rd_en", int'(bus.rd_en), int'(e.rd_en));
                    check("rd_x", int'(bus.rd_x), e.rd_x);
                    check("rd_y", int'(bus.rd_y), e.rd_y);
                    if (bus.rd_en) en_count++;
                end
            end
            @(posedge clk);
            #1;
            act = {bus.vga_pixel, bus.vga_blank_n, bus.vga_hs, bus.vga_vs};
            if (!program_resetn) begin
                last_out = 4'b0011;
                check("reset_outputs", int'(act), int'(last_out));
                check("reset_end_process", int'(bus.end_process), 0);
            end else if (have) begin
                last_out = e.out;
                check("pix_blank_hs_vs", int'(act), int'(e.out));
                check("end_process", int'(bus.end_process), int'(e.endp));
                if (bus.end_process) begin
                    end_count++;
                    end_gap = tick_count - last_end_tick;
                    last_end_tick = tick_count;
                end
                if (!bus.vga_hs) hs_low++;
                if (!bus.vga_vs) vs_low++;
            end else begin
                check("hold_outputs", int'(act), int'(last_out));
                check("end_process_between_ticks", int'(bus.end_process), 0);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: run exceeded time budget at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int en0, hs0, vs0, e0;
        program_resetn = 1'b0;
        bus.pix_ce = 1'b0;
        bus.start_process = 1'b0;
        bus.rd_data = 1'b0;
        repeat (3) @(negedge clk);
        program_resetn = 1'b1;

        repeat (30) tick(1'b0, 1'($urandom_range(0, 1)));

        repeat (3) tick(1'b1, 1'b1);
        do tick(1'b1, 1'($urandom_range(0, 1))); while (pos != 0);

        en0 = en_count; hs0 = hs_low; vs0 = vs_low; e0 = end_count;
        repeat (FT) tick(1'b1, 1'($urandom_range(0, 1)));
        check("rd_en_ticks_per_frame", en_count - en0, HA * VA);
        check("hs_low_ticks_per_frame", hs_low - hs0, HS * VT);
        check("vs_low_ticks_per_frame", vs_low - vs0, VS * HT);
        check("end_pulses_per_frame", end_count - e0, 1);
        check("end_pulse_spacing", end_gap, FT);

        while (pos / HT != 5) tick(1'b1, 1'($urandom_range(0, 1)));
        e0 = end_count;
        while (running) tick(1'b0, 1'($urandom_range(0, 1)));
        repeat (10) tick(1'b0, 1'($urandom_range(0, 1)));
        check("end_pulse_after_stop", end_count - e0, 1);

        tick(1'b1, 1'b0);
        while (pos / HT != 7) tick(1'b1, 1'($urandom_range(0, 1)));
        e0 = end_count;
        do_reset(2);
        repeat (10) tick(1'b0, 1'($urandom_range(0, 1)));
        check("no_end_pulse_on_reset", end_count - e0, 0);

        repeat (700) tick(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)));

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
